// File: rtl/hash_table_pkg.sv
// Shared types and constants for the hash_tlb block.
//   tlb_entry_t : one TLB entry (valid, address-space id, virtual and physical page numbers)
//   tlb_state_e : lookup/miss controller states
//   sat_inc     : 32-bit saturating increment used by the optional statistics counters
// Entry page-number fields are sized from PGSHIFT_DEF, the default page-offset width.
package hash_table_pkg;

    localparam int PGSHIFT_DEF = 18;
    localparam int ASID_W      = 10;
    localparam int VPN_W       = 32 - PGSHIFT_DEF;

    typedef struct packed {
        logic              v;
        logic [ASID_W-1:0] asid;
        logic [VPN_W-1:0]  vpn;
        logic [VPN_W-1:0]  ppn;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } tlb_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/hash_tlb_cam.sv
// Fully-associative entry array with parallel tag compare.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset (clears valid bits only)
//   lk_asid, lk_vpn          : lookup key
//   match                    : per-entry hit vector
//   valid                    : per-entry valid bits (used for victim selection)
//   hit_ppn                  : ppn of the lowest-index matching entry
//   wr_en, wr_idx, wr_entry  : fill port
//   inv_all, inv_asid_v, inv_asid : invalidation controls
module hash_tlb_cam
    import hash_table_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ASID_W-1:0]  lk_asid,
    input  logic [VPN_W-1:0]   lk_vpn,
    output logic [ENTRIES-1:0] match,
    output logic [ENTRIES-1:0] valid,
    output logic [VPN_W-1:0]   hit_ppn,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  tlb_entry_t         wr_entry,
    input  logic               inv_all,
    input  logic               inv_asid_v,
    input  logic [ASID_W-1:0]  inv_asid
);

    tlb_entry_t entries [ENTRIES];

    // Invalidation is evaluated after the write so that a same-cycle
    // invalidate always leaves the affected entry invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].v <= 1'b0;
            end
        end else begin
            if (wr_en) begin
                entries[wr_idx] <= wr_entry;
            end
            for (int i = 0; i < ENTRIES; i++) begin
                if (inv_all ||
                    (inv_asid_v && entries[i].asid == inv_asid) ||
                    (wr_en && wr_idx == IDX_W'(i) && inv_asid_v && wr_entry.asid == inv_asid)) begin
                    entries[i].v <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        match = '0;
        valid = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            valid[i] = entries[i].v;
            match[i] = entries[i].v && (entries[i].asid == lk_asid) && (entries[i].vpn == lk_vpn);
        end
    end

    // Descending scan: the lowest matching index is assigned last and wins.
    always_comb begin
        hit_ppn = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_ppn = entries[i].ppn;
            end
        end
    end

endmodule

// File: rtl/hash_tlb.sv
// Small fully-associative TLB in front of a hash_table page walker.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req, vadr, asid              : translation request (req held until padrv or fault)
//   padr, padrv, fault           : translation result (padrv/fault are one-cycle pulses)
//   ht_req, ht_vadr              : miss request towards hash_table
//   ht_padr, ht_padrv, ht_fault  : hash_table answer
//   inv_all, inv_asid_v, inv_asid: entry invalidation
//   hit_cnt, miss_cnt, fault_cnt : saturating statistics, present only with HASH_TLB_STATS_EN
// Addresses with bit 31 set bypass translation. Every answer passes through RESP so the
// still-high req of the answered transaction is never taken as a new request.
module hash_tlb
    import hash_table_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int PGSHIFT = PGSHIFT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] vadr,
    input  logic [9:0]  asid,
    output logic [31:0] padr,
    output logic        padrv,
    output logic        fault,
    output logic        ht_req,
    output logic [31:0] ht_vadr,
    input  logic [31:0] ht_padr,
    input  logic        ht_padrv,
    input  logic        ht_fault,
    input  logic        inv_all,
    input  logic        inv_asid_v,
    input  logic [9:0]  inv_asid
`ifdef HASH_TLB_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [31:0] fault_cnt
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    tlb_state_e         state, state_next;
    logic [ENTRIES-1:0] match, valid;
    logic [VPN_W-1:0]   hit_ppn;
    logic               hit, lookup, all_valid, inv_any, inv_seen, fill_en;
    logic [IDX_W-1:0]   rr, victim;
    logic [ASID_W-1:0]  miss_asid;
    tlb_entry_t         fill_entry;
    logic [31:0]        padr_d, ht_vadr_d;
    logic               padrv_d, fault_d, ht_req_d;

    assign hit     = |match;
    assign lookup  = (state == IDLE) && req && !vadr[31];
    assign inv_any = inv_all || inv_asid_v;

    assign fill_entry = '{v: 1'b1, asid: miss_asid,
                          vpn: ht_vadr[31:PGSHIFT], ppn: ht_padr[31:PGSHIFT]};

    hash_tlb_cam #(.ENTRIES(ENTRIES)) u_cam (
        .clk        (clk),
        .rst        (rst),
        .lk_asid    (asid),
        .lk_vpn     (vadr[31:PGSHIFT]),
        .match      (match),
        .valid      (valid),
        .hit_ppn    (hit_ppn),
        .wr_en      (fill_en),
        .wr_idx     (victim),
        .wr_entry   (fill_entry),
        .inv_all    (inv_all),
        .inv_asid_v (inv_asid_v),
        .inv_asid   (inv_asid)
    );

    // Lowest invalid entry, otherwise the round-robin pointer.
    always_comb begin
        victim    = rr;
        all_valid = &valid;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = (vadr[31] || hit) ? RESP : MISS;
            MISS: if (ht_padrv || ht_fault) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        padr_d    = padr;
        padrv_d   = 1'b0;
        fault_d   = 1'b0;
        ht_req_d  = ht_req;
        ht_vadr_d = ht_vadr;
        fill_en   = 1'b0;
        case (state)
            IDLE: begin
                if (req && vadr[31]) begin
                    padr_d  = vadr;
                    padrv_d = 1'b1;
                end else if (req && hit) begin
                    padr_d  = {hit_ppn, vadr[PGSHIFT-1:0]};
                    padrv_d = 1'b1;
                end else if (req) begin
                    ht_req_d  = 1'b1;
                    ht_vadr_d = vadr;
                end
            end
            MISS: begin
                // Fault wins over a simultaneous valid translation.
                if (ht_fault) begin
                    fault_d  = 1'b1;
                    ht_req_d = 1'b0;
                end else if (ht_padrv) begin
                    padr_d   = ht_padr;
                    padrv_d  = 1'b1;
                    ht_req_d = 1'b0;
                    // Any invalidate seen during this miss makes the fill stale.
                    fill_en  = !inv_seen && !inv_any;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            padr    <= '0;
            padrv   <= 1'b0;
            fault   <= 1'b0;
            ht_req  <= 1'b0;
            ht_vadr <= '0;
        end else begin
            padr    <= padr_d;
            padrv   <= padrv_d;
            fault   <= fault_d;
            ht_req  <= ht_req_d;
            ht_vadr <= ht_vadr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= '0;
            inv_seen  <= 1'b0;
            miss_asid <= '0;
        end else begin
            if (fill_en && all_valid) begin
                rr <= rr + 1'b1;
            end
            if (state != MISS) begin
                inv_seen <= 1'b0;
            end else if (inv_any) begin
                inv_seen <= 1'b1;
            end
            if (lookup && !hit) begin
                miss_asid <= asid;
            end
        end
    end

`ifdef HASH_TLB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            fault_cnt <= '0;
        end else begin
            if (lookup && hit)              hit_cnt   <= sat_inc(hit_cnt);
            if (lookup && !hit)             miss_cnt  <= sat_inc(miss_cnt);
            if (state == MISS && ht_fault)  fault_cnt <= sat_inc(fault_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_hash_tlb.sv
// Self-checking bench for hash_tlb (default build, ENTRIES=8, PGSHIFT=18).
// A reference model of the entry table (valid/asid/vpn/ppn arrays plus a
// round-robin pointer) predicts hit/miss and translated addresses.
module tb_hash_tlb;

    localparam int PG = 18;
    localparam int NE = 8;

    logic        clk = 1'b0;
    logic        rst, req, ht_padrv, ht_fault, inv_all, inv_asid_v;
    logic [31:0] vadr, ht_padr;
    logic [9:0]  asid, inv_asid;
    logic [31:0] padr, ht_vadr;
    logic        padrv, fault, ht_req;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_v    [NE];
    logic [9:0]  m_asid [NE];
    logic [13:0] m_vpn  [NE];
    logic [13:0] m_ppn  [NE];
    int          m_rr;

    always #5 clk = ~clk;

    hash_tlb dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .vadr       (vadr),
        .asid       (asid),
        .padr       (padr),
        .padrv      (padrv),
        .fault      (fault),
        .ht_req     (ht_req),
        .ht_vadr    (ht_vadr),
        .ht_padr    (ht_padr),
        .ht_padrv   (ht_padrv),
        .ht_fault   (ht_fault),
        .inv_all    (inv_all),
        .inv_asid_v (inv_asid_v),
        .inv_asid   (inv_asid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) m_v[i] = 1'b0;
        m_rr = 0;
    endfunction

    function automatic int model_lookup(input logic [31:0] va, input logic [9:0] as);
        logic [13:0] vpn;
        vpn = va[31:PG];
        for (int i = 0; i < NE; i++)
            if (m_v[i] && m_asid[i] == as && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    function automatic void model_fill(input logic [13:0] vpn, input logic [9:0] as, input logic [13:0] ppn);
        int vic;
        vic = -1;
        for (int i = 0; i < NE; i++)
            if (!m_v[i] && vic < 0) vic = i;
        if (vic < 0) begin
            vic  = m_rr;
            m_rr = (m_rr + 1) % NE;
        end
        m_v[vic] = 1'b1; m_asid[vic] = as; m_vpn[vic] = vpn; m_ppn[vic] = ppn;
    endfunction

    function automatic void model_inv(input bit all, input logic [9:0] as);
        for (int i = 0; i < NE; i++)
            if (all || m_asid[i] == as) m_v[i] = 1'b0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_inv(input bit all, input logic [9:0] as);
        inv_all = all; inv_asid_v = !all; inv_asid = as;
        tick();
        inv_all = 1'b0; inv_asid_v = 1'b0;
        model_inv(all, as);
    endtask

    // One complete translation. On a miss the hash_table answers on the
    // lat-th cycle that ht_req is high; inv_mid pulses an asid invalidate
    // on the first miss cycle.
    task automatic do_req(input string tag, input logic [31:0] va, input logic [9:0] as,
                          input int lat, input bit flt, input logic [31:0] hpa, input bit inv_mid);
        int          idx, hc;
        logic [31:0] exp_pa;
        idx = model_lookup(va, as);
        req = 1'b1; vadr = va; asid = as;
        tick();
        if (va[31] || idx >= 0) begin
            exp_pa = va[31] ? va : {m_ppn[idx], va[PG-1:0]};
            check({tag, ":padrv"},  32'(padrv),  32'd1);
            check({tag, ":padr"},   padr,        exp_pa);
            check({tag, ":ht_req"}, 32'(ht_req), 32'd0);
            check({tag, ":fault"},  32'(fault),  32'd0);
        end else begin
            check({tag, ":ht_req"},  32'(ht_req), 32'd1);
            check({tag, ":ht_vadr"}, ht_vadr,     va);
            check({tag, ":early"},   32'(padrv),  32'd0);
            hc = 0;
            for (int c = 1; c <= lat; c++) begin
                if (ht_req) hc++;
                if (inv_mid && c == 1) begin inv_asid_v = 1'b1; inv_asid = as; end
                if (c == lat) begin
                    ht_padr = hpa;
                    if (flt) ht_fault = 1'b1; else ht_padrv = 1'b1;
                end
                tick();
                inv_asid_v = 1'b0; ht_padrv = 1'b0; ht_fault = 1'b0;
            end
            check({tag, ":ht_cycles"}, 32'(hc),     32'(lat));
            check({tag, ":ht_drop"},   32'(ht_req), 32'd0);
            check({tag, ":padrv"},     32'(padrv),  32'(!flt));
            check({tag, ":fault"},     32'(fault),  32'(flt));
            if (!flt) check({tag, ":padr"}, padr, hpa);
            if (inv_mid) model_inv(1'b0, as);
            if (!flt && !inv_mid) model_fill(va[31:PG], as, hpa[31:PG]);
        end
        req = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] va, hpa, rnd;
        logic [9:0]  as;
        rst = 1'b1; req = 1'b0; vadr = '0; asid = '0; ht_padr = '0;
        ht_padrv = 1'b0; ht_fault = 1'b0; inv_all = 1'b0; inv_asid_v = 1'b0; inv_asid = '0;
        do_reset();

        check("rst:padr",    padr,         32'd0);
        check("rst:padrv",   32'(padrv),   32'd0);
        check("rst:fault",   32'(fault),   32'd0);
        check("rst:ht_req",  32'(ht_req),  32'd0);
        check("rst:ht_vadr", ht_vadr,      32'd0);

        // Bypass, cold miss, hit on the same page, fault path.
        do_req("bypass", 32'h8000_1234, 10'd0, 1, 1'b0, 32'h0, 1'b0);
        do_req("cold",   32'h0004_0010, 10'd0, 5, 1'b0, 32'h0128_0010, 1'b0);
        do_req("hit",    32'h0007_FFFC, 10'd0, 1, 1'b0, 32'h0, 1'b0);
        check("hit:spec_padr", padr, 32'h012B_FFFC);
        do_req("flt1",   32'h0014_0000, 10'd0, 3, 1'b1, 32'h0, 1'b0);
        do_req("flt2",   32'h0014_0000, 10'd0, 2, 1'b0, 32'h0550_0000, 1'b0);

        // Round-robin replacement: 9 pages into 8 entries evicts page 1.
        do_reset();
        for (int p = 1; p <= 9; p++)
            do_req($sformatf("fill%0d", p), 32'(p) << PG, 10'd0, 2, 1'b0, 32'(p + 100) << PG, 1'b0);
        do_req("rr_pg2", (32'd2 << PG) | 32'h44, 10'd0, 2, 1'b0, 32'h0, 1'b0);
        check("rr_pg2:hitpadr", padr, (32'd102 << PG) | 32'h44);
        do_req("rr_pg1", 32'd1 << PG, 10'd0, 2, 1'b0, 32'd201 << PG, 1'b0);

        // Invalidate during miss: response still delivered, fill suppressed.
        do_req("inv_mid", 32'd20 << PG, 10'd3, 4, 1'b0, 32'd300 << PG, 1'b1);
        do_req("inv_rep", 32'd20 << PG, 10'd3, 2, 1'b0, 32'd301 << PG, 1'b0);
        do_req("inv_a0",  32'd3 << PG,  10'd0, 2, 1'b0, 32'h0, 1'b0);
        do_inv(1'b1, 10'd0);
        do_req("invall",  32'd3 << PG,  10'd0, 2, 1'b0, 32'd103 << PG, 1'b0);

        // Randomized mix of bypasses, hits, misses, faults and invalidates.
        for (int k = 0; k < 60; k++) begin
            rnd = $urandom_range(0, 11);
            va  = (rnd << PG) | ($urandom() & 32'h3FFFF);
            if ($urandom_range(0, 7) == 0) va[31] = 1'b1;
            as  = 10'($urandom_range(0, 1));
            rnd = $urandom_range(0, 16383);
            hpa = (rnd << PG) | {14'd0, va[PG-1:0]};
            if ($urandom_range(0, 15) == 0) do_inv($urandom_range(0, 1) == 1, as);
            do_req($sformatf("rnd%0d", k), va, as, $urandom_range(1, 4),
                   $urandom_range(0, 7) == 0, hpa, $urandom_range(0, 9) == 0);
        end

        // Reset in the middle of a miss drops ht_req and empties the table.
        req = 1'b1; vadr = 32'd3 << PG; asid = 10'd0;
        tick();
        if (model_lookup(vadr, asid) < 0) check("rstmiss:ht_req", 32'(ht_req), 32'd1);
        rst = 1'b1;
        tick();
        check("rstmiss:drop", 32'(ht_req), 32'd0);
        check("rstmiss:padrv", 32'(padrv), 32'd0);
        rst = 1'b0; req = 1'b0;
        model_reset();
        tick();
        do_req("post_rst", 32'd3 << PG, 10'd0, 2, 1'b0, 32'd77 << PG, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
